// File: rtl/div_iter_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_iter_unit_pkg
// Shared definitions for the iterative divide unit: the AluCtrl opcode
// encodings, the data width, the divider FSM state codes and opcode
// classification helpers.
// -----------------------------------------------------------------------------
package div_iter_unit_pkg;

    // Width of the DType datapath; the divider operand width must match it.
    localparam int DTYPE_W = 32;

    typedef logic [4:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_ADD  = 5'd0;
    localparam alu_ctrl_t ALU_SUB  = 5'd1;
    localparam alu_ctrl_t ALU_AND  = 5'd2;
    localparam alu_ctrl_t ALU_OR   = 5'd3;
    localparam alu_ctrl_t ALU_XOR  = 5'd4;
    localparam alu_ctrl_t ALU_SLL  = 5'd5;
    localparam alu_ctrl_t ALU_SRL  = 5'd6;
    localparam alu_ctrl_t ALU_SRA  = 5'd7;
    localparam alu_ctrl_t ALU_SLT  = 5'd8;
    localparam alu_ctrl_t ALU_SLTU = 5'd9;
    localparam alu_ctrl_t ALU_MUL  = 5'd10;
    localparam alu_ctrl_t ALU_DIV  = 5'd12;
    localparam alu_ctrl_t ALU_MOD  = 5'd13;
    localparam alu_ctrl_t ALU_DIVU = 5'd14;
    localparam alu_ctrl_t ALU_MODU = 5'd15;

    // Divider FSM state codes (DivState)
    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_CALC = 2'd1;
    localparam logic [1:0] DIV_FIX  = 2'd2;
    localparam logic [1:0] DIV_DONE = 2'd3;

    function automatic logic isDivOp(input alu_ctrl_t op);
        return (op == ALU_DIV) || (op == ALU_MOD) ||
               (op == ALU_DIVU) || (op == ALU_MODU);
    endfunction

    function automatic logic isSignedDivOp(input alu_ctrl_t op);
        return (op == ALU_DIV) || (op == ALU_MOD);
    endfunction

    // Remainder-selecting opcodes; the other divide opcodes return the quotient.
    function automatic logic isRemOp(input alu_ctrl_t op);
        return (op == ALU_MOD) || (op == ALU_MODU);
    endfunction

endpackage

// File: rtl/div_iter_unit_if.sv
// -----------------------------------------------------------------------------
// div_iter_unit_if
// Execute-stage <-> divider handshake bundle.
//   start_i  : request, sampled only while the divider is idle
//   op_i     : AluCtrl opcode
//   src1_i   : dividend (rj)
//   src2_i   : divisor (rk)
//   flush_i  : abort the in-flight operation
//   busy_o   : divider occupied (CALC/FIX)
//   done_o   : one-cycle completion pulse, result_o valid
//   result_o : quotient or remainder, held until the next accepted start
// master = execute stage, slave = divider.
// -----------------------------------------------------------------------------
interface div_iter_unit_if;
    import div_iter_unit_pkg::*;

    logic                 start_i;
    alu_ctrl_t            op_i;
    logic [DTYPE_W-1:0]   src1_i;
    logic [DTYPE_W-1:0]   src2_i;
    logic                 flush_i;
    logic                 busy_o;
    logic                 done_o;
    logic [DTYPE_W-1:0]   result_o;

    modport master (
        output start_i, op_i, src1_i, src2_i, flush_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, op_i, src1_i, src2_i, flush_i,
        output busy_o, done_o, result_o
    );

endinterface

// File: rtl/div_iter_unit_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One radix-2 restoring division step, purely combinational.
//   rem_i     : partial remainder before the step (always < divisor)
//   divisor_i : divisor magnitude
//   bit_i     : next dividend bit, MSB first
//   rem_o     : partial remainder after the step
//   q_o       : quotient bit produced by this step
// The shifted partial remainder needs W+1 bits; its top bit is also the
// sign of the trial subtraction, which decides whether to restore.
// -----------------------------------------------------------------------------
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] divisor_i,
    input  logic         bit_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);

    logic [W:0] shifted;
    logic [W:0] trial;

    always_comb begin
        shifted = {rem_i, bit_i};
        trial   = shifted - {1'b0, divisor_i};
        q_o     = ~trial[W];
        // A negative trial means the divisor did not fit: keep the shifted
        // value. Either way the result is below the divisor, so W bits hold it.
        rem_o   = trial[W] ? shifted[W-1:0] : trial[W-1:0];
    end

endmodule

// File: rtl/div_iter_unit.sv
// -----------------------------------------------------------------------------
// div_iter_unit
// Multi-cycle radix-2 restoring integer divider for DIV/MOD/DIVU/MODU.
// Fixed latency: XLEN CALC cycles, one FIX cycle, one DONE cycle.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : div_iter_unit_if.slave (start/op/src1/src2/flush in,
//         busy/done/result out)
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for an accepted start
//   CALC  | one quotient bit per cycle, MSB first, XLEN cycles
//   FIX   | apply signs and special cases, register result
//   DONE  | done_o pulse for one cycle
// -----------------------------------------------------------------------------
module div_iter_unit
    import div_iter_unit_pkg::*;
#(
    parameter int XLEN  = DTYPE_W,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    div_iter_unit_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    alu_ctrl_t        op_q, op_d;
    logic             sign1_q, sign1_d;
    logic             sign2_q, sign2_d;
    logic             div0_q, div0_d;
    logic             ovf_q, ovf_d;
    logic [XLEN-1:0]  dvd_q, dvd_d;
    logic [XLEN-1:0]  dsr_q, dsr_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quot_q, quot_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic             accept;
    logic             src_signed;
    logic [XLEN-1:0]  step_rem;
    logic             step_q;
    logic [XLEN-1:0]  quot_fix;
    logic [XLEN-1:0]  rem_fix;

    div_step #(.W(XLEN)) u_step (
        .rem_i     (rem_q),
        .divisor_i (dsr_q),
        .bit_i     (dvd_q[XLEN-1]),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    assign src_signed = isSignedDivOp(bus.op_i);
    assign accept     = (state_q == DIV_IDLE) && bus.start_i &&
                        isDivOp(bus.op_i) && !bus.flush_i;

    // Sign and special-case correction of the magnitude results.
    always_comb begin
        quot_fix = (sign1_q ^ sign2_q) ? -quot_q : quot_q;
        // With a zero divisor every trial succeeds, so the remainder path
        // reproduces |src1| and the dividend sign restores src1 exactly.
        rem_fix  = sign1_q ? -rem_q : rem_q;
        if (div0_q) begin
            quot_fix = '1;
        end else if (ovf_q) begin
            quot_fix = MIN_NEG;
            rem_fix  = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE: if (accept) state_d = DIV_CALC;
            DIV_CALC: begin
                if (bus.flush_i)            state_d = DIV_IDLE;
                else if (cnt_q == LAST_CNT) state_d = DIV_FIX;
            end
            DIV_FIX:  state_d = bus.flush_i ? DIV_IDLE : DIV_DONE;
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        result_d = result_q;

        if (accept) begin
            op_d    = bus.op_i;
            sign1_d = src_signed && bus.src1_i[XLEN-1];
            sign2_d = src_signed && bus.src2_i[XLEN-1];
            dvd_d   = sign1_d ? -bus.src1_i : bus.src1_i;
            dsr_d   = sign2_d ? -bus.src2_i : bus.src2_i;
            div0_d  = (bus.src2_i == '0);
            ovf_d   = src_signed && (bus.src1_i == MIN_NEG) &&
                      (bus.src2_i == '1);
            rem_d   = '0;
            quot_d  = '0;
            cnt_d   = '0;
        end else if ((state_q == DIV_CALC) && !bus.flush_i) begin
            rem_d  = step_rem;
            quot_d = {quot_q[XLEN-2:0], step_q};
            dvd_d  = {dvd_q[XLEN-2:0], 1'b0};
            cnt_d  = cnt_q + 1'b1;
        end else if ((state_q == DIV_FIX) && !bus.flush_i) begin
            result_d = isRemOp(op_q) ? rem_fix : quot_fix;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            dvd_q    <= dvd_d;
            dsr_q    <= dsr_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            result_q <= result_d;
        end
    end

    assign bus.busy_o   = (state_q == DIV_CALC) || (state_q == DIV_FIX);
    assign bus.done_o   = (state_q == DIV_DONE);
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_div_iter_unit.sv
module tb_div_iter_unit;
    import div_iter_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned cyc = 0;

    div_iter_unit_if bus ();

    div_iter_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int unsigned acc_cyc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_res = '0;
    int          busy_run = 0;
    bit          prev_done = 1'b0;

    // Reference: plain 64-bit arithmetic, special cases from the op rules.
    function automatic logic [31:0] ref_model(alu_ctrl_t op, logic [31:0] a, logic [31:0] b);
        longint sa, sbv, q, r;
        bit sgn, rem;
        sgn = (op == ALU_DIV) || (op == ALU_MOD);
        rem = (op == ALU_MOD) || (op == ALU_MODU);
        if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
        sa  = sgn ? longint'($signed(a)) : longint'(a);
        sbv = sgn ? longint'($signed(b)) : longint'(b);
        q = sa / sbv;
        r = sa % sbv;
        return rem ? r[31:0] : q[31:0];
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: pops the oldest expectation on every done_o.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.done_o) begin
                check("done_single_cycle", 32'(prev_done), 32'd0);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done_o=1 expected no pending op");
                end else begin
                    e = sb.pop_front();
                    check(e.name, bus.result_o, e.res);
                    check({e.name, "_latency"}, cyc - e.acc_cyc, 32'd33);
                    check({e.name, "_busy_len"}, 32'(busy_run), 32'd33);
                end
                busy_run = 0;
            end else if (bus.busy_o) begin
                busy_run++;
            end else begin
                busy_run = 0;
            end
        end else begin
            busy_run = 0;
        end
        prev_done = bus.done_o;
    end

    task automatic wait_idle();
        int i;
        i = 0;
        @(negedge clk);
        while ((bus.busy_o || bus.done_o) && i < 100) begin
            @(negedge clk);
            i++;
        end
        if (i >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle_timeout: got busy=%0b expected idle", bus.busy_o);
        end
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while (sb.size() != 0 && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (i >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        @(negedge clk);
    endtask

    // Issue one operation at a negedge; accepted at the next posedge.
    // Operands are scrambled right after the accept edge.
    task automatic issue(alu_ctrl_t op, logic [31:0] a, logic [31:0] b, bit push, string nm);
        exp_t e;
        wait_idle();
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.src1_i  = a;
        bus.src2_i  = b;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.op_i    = alu_ctrl_t'($urandom);
        bus.src1_i  = $urandom;
        bus.src2_i  = $urandom;
        if (push) begin
            e.res     = ref_model(op, a, b);
            e.acc_cyc = cyc;
            e.name    = nm;
            sb.push_back(e);
            last_res  = e.res;
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        alu_ctrl_t ops[4];
        ops[0] = ALU_DIV; ops[1] = ALU_MOD; ops[2] = ALU_DIVU; ops[3] = ALU_MODU;

        bus.start_i = 1'b0;
        bus.op_i    = ALU_ADD;
        bus.src1_i  = '0;
        bus.src2_i  = '0;
        bus.flush_i = 1'b0;

        #12;
        check("reset_busy", 32'(bus.busy_o), 32'd0);
        check("reset_done", 32'(bus.done_o), 32'd0);
        check("reset_result", bus.result_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic unsigned and back-to-back
        issue(ALU_DIVU, 32'd100, 32'd7, 1, "divu_100_7");
        issue(ALU_MODU, 32'd100, 32'd7, 1, "modu_100_7");
        // Signed
        issue(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 1, "div_m7_2");
        issue(ALU_MOD, 32'hFFFF_FFF9, 32'd2, 1, "mod_m7_2");
        issue(ALU_MOD, 32'd7, 32'hFFFF_FFFE, 1, "mod_7_m2");
        // Overflow
        issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, "div_ovf");
        issue(ALU_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 1, "mod_ovf");
        // Divide by zero
        issue(ALU_DIVU, 32'd5, 32'd0, 1, "divu_by0");
        issue(ALU_MODU, 32'd5, 32'd0, 1, "modu_by0");
        issue(ALU_DIV, 32'hFFFF_FFF9, 32'd0, 1, "div_by0");
        issue(ALU_MOD, 32'hFFFF_FFF9, 32'd0, 1, "mod_by0");
        wait_drain();

        // Flush in CALC iteration 10, then an immediate new op
        issue(ALU_DIVU, 32'd1000, 32'd3, 0, "flushed");
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        @(negedge clk);
        check("flush_busy", 32'(bus.busy_o), 32'd0);
        check("flush_result_held", bus.result_o, last_res);
        issue(ALU_DIVU, 32'd9, 32'd3, 1, "divu_after_flush");
        wait_drain();

        // Non-divide op ignored
        wait_idle();
        bus.start_i = 1'b1;
        bus.op_i    = ALU_ADD;
        bus.src1_i  = 32'd4;
        bus.src2_i  = 32'd2;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        @(negedge clk);
        check("add_ignored_busy", 32'(bus.busy_o), 32'd0);
        check("add_ignored_result", bus.result_o, last_res);

        // start with flush in IDLE: flush wins
        bus.start_i = 1'b1;
        bus.flush_i = 1'b1;
        bus.op_i    = ALU_DIVU;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        @(negedge clk);
        check("flush_start_busy", 32'(bus.busy_o), 32'd0);

        // start while busy is ignored
        issue(ALU_DIVU, 32'hDEAD_BEEF, 32'h0000_1234, 1, "divu_busy_start");
        repeat (5) @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = ALU_DIV;
        bus.src1_i  = 32'd77;
        bus.src2_i  = 32'd5;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        wait_drain();

        // Reset mid-CALC
        issue(ALU_DIV, 32'h1234_5678, 32'd13, 0, "reset_victim");
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.busy_o), 32'd0);
        check("midrst_done", 32'(bus.done_o), 32'd0);
        check("midrst_result", bus.result_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_res = '0;
        issue(ALU_MODU, 32'd10, 32'd4, 1, "modu_after_reset");

        // Randomized
        for (int k = 0; k < 40; k++) begin
            alu_ctrl_t   op;
            logic [31:0] a, b;
            op = ops[$urandom_range(0, 3)];
            a  = rand_operand();
            b  = rand_operand();
            issue(op, a, b, 1, $sformatf("rand%0d", k));
        end
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
